// File: rtl/blink_pkg.sv
// blink_pkg: I/O port addresses and timer status bit indices shared across the blink gate array.
package blink_pkg;
    localparam logic [7:0] ADDR_TACK = 8'hB4;
    localparam logic [7:0] ADDR_TMK  = 8'hB5;
    localparam logic [7:0] ADDR_TSTA = 8'hB5;
    localparam logic [7:0] ADDR_TIM0 = 8'hD0;
    localparam logic [7:0] ADDR_TIM1 = 8'hD1;
    localparam logic [7:0] ADDR_TIM2 = 8'hD2;
    localparam logic [7:0] ADDR_TIM3 = 8'hD3;
    localparam logic [7:0] ADDR_TIM4 = 8'hD4;
    localparam int TSTA_TICK = 0;
    localparam int TSTA_SEC  = 1;
    localparam int TSTA_MIN  = 2;
endpackage

// File: rtl/rtc_stat_latch.sv
// rtc_stat_latch: sticky status bit; set beats clear so a coincident event is never lost.
module rtc_stat_latch (
    input  logic mck,
    input  logic rin_n,
    input  logic set,
    input  logic clr,
    output logic q
);
    always_ff @(posedge mck or negedge rin_n)
        if (!rin_n) q <= 1'b0;
        else        q <= set ? 1'b1 : clr ? 1'b0 : q;
endmodule

// File: rtl/blink_rtc.sv
// blink_rtc: prescaled tick -> second -> minute counters with sticky masked interrupt status
// and tearing-free snapshot reads of the upper counters.
module blink_rtc
    import blink_pkg::*;
#(
    parameter int TICK_DIV = 49153,
    parameter int TIM0_MAX = 199,
    parameter int TIM1_MAX = 59,
    parameter int TIMM_W   = 21
) (
    input  logic       mck,
    input  logic       rin_n,
    input  logic       tick_en,
    input  logic       restim,
    input  logic       reg_wr,
    input  logic       reg_rd,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic [2:0] tsta,
    output logic       rtc_int,
    output logic       tick_pls
);
    localparam int TCK_W = $clog2(TICK_DIV);
    localparam int T0_W  = $clog2(TIM0_MAX + 1);
    localparam int T1_W  = $clog2(TIM1_MAX + 1);

    logic [TCK_W-1:0]  tck;
    logic [T0_W-1:0]   tim0;
    logic [T1_W-1:0]   tim1, sh_t1;
    logic [TIMM_W-1:0] timm, sh_tm;
    logic [2:0]        tmk, ev;
    logic [23:0]       tm24;
    logic [7:0]        rd_nxt;
    logic              ovf, tick, sec, min, wrap, tack, rd_hit;
    logic              unused_wdata;

    assign tick    = tick_en && !restim && tck == TCK_W'(TICK_DIV - 1);
    assign sec     = tick && tim0 == T0_W'(TIM0_MAX);
    assign min     = sec && tim1 == T1_W'(TIM1_MAX);
    assign wrap    = min && &timm;
    assign ev      = {min, sec, tick};
    assign tack    = reg_wr && reg_addr == ADDR_TACK;
    assign rtc_int = |(tsta & tmk);
    assign tm24    = 24'(sh_tm);
    assign unused_wdata = ^reg_wdata[6:3];

    always_ff @(posedge mck or negedge rin_n)
        if (!rin_n) begin
            tck      <= '0;
            tim0     <= '0;
            tim1     <= '0;
            timm     <= '0;
            tick_pls <= 1'b0;
        end else begin
            tick_pls <= tick;
            if (restim) begin
                tck  <= '0;
                tim0 <= '0;
                tim1 <= '0;
                timm <= '0;
            end else begin
                if (tick_en) tck <= tick ? '0 : tck + 1'b1;
                if (tick)    tim0 <= sec ? '0 : tim0 + 1'b1;
                if (sec)     tim1 <= min ? '0 : tim1 + 1'b1;
                if (min)     timm <= timm + 1'b1;
            end
        end

    for (genvar i = 0; i < 3; i++) begin : g_sta
        rtc_stat_latch u_sta (
            .mck   (mck),
            .rin_n (rin_n),
            .set   (ev[i]),
            .clr   (tack && reg_wdata[i]),
            .q     (tsta[i])
        );
    end

    rtc_stat_latch u_ovf (
        .mck   (mck),
        .rin_n (rin_n),
        .set   (wrap),
        .clr   (tack && reg_wdata[7]),
        .q     (ovf)
    );

    always_comb begin
        rd_hit = reg_rd && (reg_addr == ADDR_TSTA || (reg_addr >= ADDR_TIM0 && reg_addr <= ADDR_TIM4));
        rd_nxt = reg_addr == ADDR_TSTA ? {ovf, 4'b0, tsta} :
                 reg_addr == ADDR_TIM0 ? 8'(tim0) :
                 reg_addr == ADDR_TIM1 ? 8'(sh_t1) :
                 reg_addr == ADDR_TIM2 ? tm24[7:0] :
                 reg_addr == ADDR_TIM3 ? tm24[15:8] : tm24[23:16];
    end

    // Reading TIM0 freezes tim1/timm so a multi-byte read sees one consistent instant.
    always_ff @(posedge mck or negedge rin_n)
        if (!rin_n) begin
            tmk       <= '0;
            reg_rdata <= '0;
            sh_t1     <= '0;
            sh_tm     <= '0;
        end else begin
            if (reg_wr && reg_addr == ADDR_TMK) tmk <= reg_wdata[2:0];
            if (rd_hit) reg_rdata <= rd_nxt;
            if (reg_rd && reg_addr == ADDR_TIM0) begin
                sh_t1 <= tim1;
                sh_tm <= timm;
            end
        end
endmodule
